modexp_ctrl: RTL

MODEXP_CTRL -- requirements
Module: modexp_ctrl

---
 rtl/modexp_ctrl_pkg.sv | 21 ++
 rtl/modexp_ctrl.sv | 100 ++++++++++
 2 files changed

// File: rtl/modexp_ctrl_pkg.sv
// modexp_ctrl_pkg: shared FSM encoding, operation tags and default sizes for the modexp controller
package modexp_ctrl_pkg;
  localparam int WIDTH_DEF = 1024;
  localparam int TW_DEF = 10;
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    TOMONT   = 4'd1,
    SQUARE   = 4'd2,
    MULT     = 4'd3,
    WAIT     = 4'd4,
    DECIDE   = 4'd5,
    FROMMONT = 4'd6,
    DONE     = 4'd7
  } state_t;
  typedef enum logic [1:0] {
    OP_TOMONT   = 2'd0,
    OP_SQUARE   = 2'd1,
    OP_MULT     = 2'd2,
    OP_FROMMONT = 2'd3
  } op_t;
endpackage

// File: rtl/modexp_ctrl.sv
// modexp_ctrl: left-to-right square-and-multiply sequencer driving one external Montgomery core
module modexp_ctrl
  import modexp_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int TW = TW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_m,
  input  logic [WIDTH-1:0] in_e,
  input  logic [WIDTH-1:0] in_r,
  input  logic [WIDTH-1:0] in_r2,
  input  logic [TW-1:0]    in_t,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic [WIDTH-1:0] mont_a,
  output logic [WIDTH-1:0] mont_b,
  output logic [WIDTH-1:0] mont_m,
  output logic             mont_start,
  input  logic [WIDTH-1:0] mont_result,
  input  logic             mont_done
);
  state_t state;
  op_t op, op_nx;
  logic [WIDTH-1:0] m_q, e_q, r2_q, xm, acc, a_nx, b_nx;
  logic [TW-1:0] idx;
  // xm holds the raw base until the first core operation replaces it with x in Montgomery form
  always_comb begin
    a_nx = state == TOMONT ? xm : acc;
    b_nx = state == TOMONT ? r2_q : state == SQUARE ? acc : state == MULT ? xm : WIDTH'(1);
    op_nx = state == TOMONT ? OP_TOMONT : state == SQUARE ? OP_SQUARE : state == MULT ? OP_MULT : OP_FROMMONT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op <= OP_TOMONT;
      busy <= 1'b0;
      done <= 1'b0;
      mont_start <= 1'b0;
      result <= '0;
      mont_a <= '0;
      mont_b <= '0;
      mont_m <= '0;
      m_q <= '0;
      e_q <= '0;
      r2_q <= '0;
      xm <= '0;
      acc <= '0;
      idx <= '0;
    end else begin
      mont_start <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          xm <= in_x;
          r2_q <= in_r2;
          acc <= in_r;
          m_q <= in_m;
          e_q <= in_e;
          idx <= in_t;
          busy <= 1'b1;
          state <= TOMONT;
        end
        TOMONT, SQUARE, MULT, FROMMONT: begin
          mont_a <= a_nx;
          mont_b <= b_nx;
          mont_m <= m_q;
          op <= op_nx;
          mont_start <= 1'b1;
          state <= WAIT;
        end
        WAIT: if (mont_done) state <= DECIDE;
        DECIDE: begin
          case (op)
            OP_TOMONT: xm <= mont_result;
            OP_FROMMONT: result <= mont_result;
            default: acc <= mont_result;
          endcase
          if (op == OP_FROMMONT) begin
            busy <= 1'b0;
            done <= 1'b1;
            state <= DONE;
          end else if (op == OP_TOMONT) state <= SQUARE;
          else if (op == OP_SQUARE && e_q[idx]) state <= MULT;
          else if (idx == '0) state <= FROMMONT;
          else begin
            idx <= idx - 1'b1;
            state <= SQUARE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
